// File: rtl/game_pkg.sv
// Shared types and default constants for the UW game frame sequencer.
package game_pkg;

  localparam int unsigned COORD_W          = 10;
  localparam int unsigned SCORE_W          = 8;
  localparam int unsigned ANIMATION_LENGTH = 110;
  localparam int unsigned ANIM_STEP        = 3;
  localparam int unsigned SCROLL_STEP      = 4;
  localparam int unsigned SCROLL_WRAP      = 400;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INTRO = 2'd1,
    PLAY  = 2'd2,
    OVER  = 2'd3
  } state_t;

endpackage

// File: rtl/game_sequencer_rise_detect.sv
// Rising-edge detector: one-cycle pulse when d goes low -> high.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic pulse
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (reset) d_q <= 1'b0;
    else       d_q <= d;
  end

  assign pulse = d & ~d_q;

endmodule

// File: rtl/game_sequencer.sv
// Frame-rate controller for the UW game: intro animation, scrolling play, game-over.
// Optional pause button enabled by defining GAME_PAUSE_EN.
module game_sequencer #(
  parameter int unsigned ANIMATION_LENGTH = game_pkg::ANIMATION_LENGTH,
  parameter int unsigned ANIM_STEP        = game_pkg::ANIM_STEP,
  parameter int unsigned SCROLL_STEP      = game_pkg::SCROLL_STEP,
  parameter int unsigned SCROLL_WRAP      = game_pkg::SCROLL_WRAP
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          vsync,
  input  logic                          start_btn,
  input  logic                          collision,
`ifdef GAME_PAUSE_EN
  input  logic                          pause_btn,
`endif
  output logic                          frame_tick,
  output logic [1:0]                    state,
  output logic [game_pkg::COORD_W-1:0]  animation,
  output logic [game_pkg::COORD_W-1:0]  x_offset,
  output logic                          game_started,
  output logic                          game_over,
  output logic [game_pkg::SCORE_W-1:0]  score
);

  import game_pkg::*;

  localparam logic [COORD_W:0] ANIM_MAX = (COORD_W+1)'(ANIMATION_LENGTH);
  localparam logic [COORD_W:0] ANIM_INC = (COORD_W+1)'(ANIM_STEP);
  localparam logic [COORD_W:0] SCR_INC  = (COORD_W+1)'(SCROLL_STEP);
  localparam logic [COORD_W:0] SCR_WRAP = (COORD_W+1)'(SCROLL_WRAP);

  state_t             st;
  logic               hit_pending;
  logic               start_press;
  logic               play_active;
  logic [COORD_W:0]   anim_sum;
  logic [COORD_W:0]   x_sum;
  logic               x_wrap;
  logic [COORD_W-1:0] anim_next;
  logic [COORD_W-1:0] x_next;

  rise_detect u_vsync_edge (.clk(clk), .reset(reset), .d(vsync),     .pulse(frame_tick));
  rise_detect u_start_edge (.clk(clk), .reset(reset), .d(start_btn), .pulse(start_press));

`ifdef GAME_PAUSE_EN
  logic pause_press;
  logic paused;

  rise_detect u_pause_edge (.clk(clk), .reset(reset), .d(pause_btn), .pulse(pause_press));

  always_ff @(posedge clk) begin
    if (reset || st != PLAY) paused <= 1'b0;
    else if (pause_press)    paused <= ~paused;
  end

  assign play_active = ~paused;
`else
  assign play_active = 1'b1;
`endif

  // One bit of headroom so the wrap/clamp compare sees the true sum.
  always_comb begin
    anim_sum  = {1'b0, animation} + ANIM_INC;
    x_sum     = {1'b0, x_offset} + SCR_INC;
    x_wrap    = (x_sum >= SCR_WRAP);
    anim_next = (anim_sum >= ANIM_MAX) ? ANIM_MAX[COORD_W-1:0] : anim_sum[COORD_W-1:0];
    x_next    = x_wrap ? (x_sum - SCR_WRAP) : x_sum;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st          <= IDLE;
      animation   <= '0;
      x_offset    <= '0;
      score       <= '0;
      hit_pending <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          animation <= '0;
          x_offset  <= '0;
          if (start_press) begin
            st          <= INTRO;
            score       <= '0;
            hit_pending <= 1'b0;
          end
        end
        INTRO: begin
          if (frame_tick) begin
            if (animation == ANIM_MAX[COORD_W-1:0]) st <= PLAY;
            else                                    animation <= anim_next;
          end
        end
        PLAY: begin
          if (!play_active) begin
            hit_pending <= 1'b0;
          end else if (frame_tick) begin
            hit_pending <= 1'b0;
            if (hit_pending || collision) begin
              st <= OVER;
            end else begin
              x_offset <= x_next;
              if (x_wrap && score != '1) score <= score + 1'b1;
            end
          end else if (collision) begin
            hit_pending <= 1'b1;
          end
        end
        OVER: begin
          if (start_press) begin
            st          <= INTRO;
            animation   <= '0;
            x_offset    <= '0;
            score       <= '0;
            hit_pending <= 1'b0;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign state        = st;
  assign game_started = (st == PLAY) || (st == OVER);
  assign game_over    = (st == OVER);

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
Frame-level controller for the sine-wave "UW" game. It runs on the pixel clock and detects frame boundaries from the vsync output of the sync generator. It sequences the intro box-grow animation, the scrolling play phase and game-over, and supplies the `animation`, `x_offset`, `game_started` and `score` values consumed by the scene, player and colour-mux logic. The scene and player renderers are purely combinational; this block owns all frame-rate state.

Parameters:
- ANIMATION_LENGTH, 110, final box half-height reached by the intro.
- ANIM_STEP, 3, intro growth per frame.
- SCROLL_STEP, 4, x_offset advance per frame in PLAY.
- SCROLL_WRAP, 400, x_offset modulus (10 bars × 40 px).

Ports:
- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-high reset.
- vsync  in  1  vsync from the sync generator (active-high pulse).
- start_btn  in  1  start/restart button, level, already synchronised.
- collision  in  1  per-pixel pulse (player pixel AND sine pixel during active video).
- frame_tick  out  1  one-cycle pulse on the vsync rising edge.
- state  out  2  current FSM state.
- animation  out  10  intro size to the scene renderer.
- x_offset  out  10  scroll offset.
- game_started  out  1  high in PLAY and OVER (shows box-complete scene and player).
- game_over  out  1  high in OVER.
- score  out  8  completed scroll wraps, saturating.

Behaviour:
- All state updates occur on clk. Nothing is clocked from vsync.
- Reset: state=IDLE, animation=0, x_offset=0, score=0, hit_pending=0, edge-detect history=0. All outputs are 0.
- frame_tick = vsync & ~vsync_q. It is combinational from the registered history, so it lasts exactly one cycle per frame. State changes made on the tick cycle are visible on the next cycle.
- start_press = start_btn & ~start_q, a one-cycle pulse. A held button counts once.
- FSM states (2-bit): IDLE=0, INTRO=1, PLAY=2, OVER=3.
- IDLE:
  - animation=0, x_offset=0.
  - start_press → INTRO, score cleared. The transition does not wait for a tick.
- INTRO: on each tick:
  - if animation==ANIMATION_LENGTH → PLAY;
  - else animation ← min(animation+ANIM_STEP, ANIMATION_LENGTH).
  - With defaults the sequence is 0,3,…,108,110, and PLAY is entered on the 38th tick.
  - start_press and collision are ignored.
- PLAY:
  - animation holds at ANIMATION_LENGTH.
  - collision sets hit_pending (sticky).
  - On each tick, if (hit_pending | collision) → OVER and x_offset holds.
  - Otherwise x_offset ← x_offset+SCROLL_STEP, minus SCROLL_WRAP if the sum is ≥ SCROLL_WRAP. When the subtraction happens, score ← score+1, saturating at 255.
  - hit_pending clears on every tick.
  - start_press is ignored.
- OVER:
  - All values freeze; game_over=1.
  - start_press → INTRO with animation=0, x_offset=0, score=0, hit_pending=0.
- Simultaneous events:
  - tick and start_press in IDLE/OVER: the start transition wins and the tick is ignored that cycle.
  - collision on the tick cycle counts toward the current frame's decision.
- Arithmetic is done 11-bit wide to avoid overflow before the wrap compare.
- Reset asserted mid-game returns to IDLE on the next edge regardless of state.

Optional Feature:
- GAME_PAUSE_EN defined:
  - adds input pause_btn (1 bit) with its own edge detect;
  - a press in PLAY toggles `paused`;
  - while paused, ticks do not advance x_offset and collision is ignored, and hit_pending is also cleared;
  - paused clears on leaving PLAY and on reset.
- Undefined: no pause_btn port and no paused register; behaviour is exactly as above.

Decomposition:
- Package game_pkg:
  - state_t enum (IDLE/INTRO/PLAY/OVER, 2-bit);
  - default constants (ANIMATION_LENGTH, ANIM_STEP, SCROLL_STEP, SCROLL_WRAP);
  - width constants COORD_W=10 and SCORE_W=8.
- One sub-module: rise_detect (clk, reset, d → pulse), instanced for vsync, start_btn and (with the macro) pause_btn.

Test Plan:
- Reset, then 5 vsync pulses with no start → state=0, animation=0, x_offset=0, all outputs 0.
- start_btn held 100 cycles, then ticks → a single INTRO entry; animation reads 3 after tick 1 and 108 after tick 36, reaches 110 after tick 37, and state=2 after tick 38.
- In PLAY with x_offset=396, a tick → x_offset=0 and score increments by 1. With score=255, a wrap leaves score=255.
- In PLAY, one collision pulse mid-frame → at the next tick state=3, game_over=1, x_offset unchanged. Further ticks cause no change.
- collision asserted on the exact tick cycle → OVER on that tick. Collision during INTRO → no effect.
- From OVER, start_press → INTRO, animation=0, x_offset=0, score=0. Asserting reset mid-INTRO → IDLE and all zeros next cycle.
